// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, default bit time and byte type.
// Imported by the TX path, the AXI-Lite slave and the receiver.
package uart_pkg;

    // 100 MHz system clock, 115200 baud.
    localparam int UART_CLKS_PER_BIT = 868;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [2:0] {
        UART_IDLE    = 3'd0,
        UART_START   = 3'd1,
        UART_DATA    = 3'd2,
        UART_STOP    = 3'd3,
        UART_CLEANUP = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count/full/empty and sticky overflow.
// Ports: push/wr_data in, pop/rd_data out (show-ahead head), full, empty,
// count, overflow (set on dropped push, cleared by clr_overflow).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     clr_overflow,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the pre-edge value, so a push into a full FIFO is
    // dropped even when a pop frees a slot at the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
            // A drop in the same cycle as a clear keeps the flag set.
            if (push && full) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes are queued in a FIFO and serialised.
// Ports: i_wr_en/i_wr_data push, i_clr_overflow; o_full/o_empty/o_count/
// o_overflow FIFO status; o_tx_serial line, o_tx_active, o_tx_done, o_sm_state.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic [7:0]                    i_wr_data,
    input  logic                          i_clr_overflow,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow,
    output logic                          o_tx_serial,
    output logic                          o_tx_active,
    output logic                          o_tx_done,
    output logic [2:0]                    o_sm_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    uart_byte_t    tx_byte;
    uart_byte_t    head;
    logic          pop;
    logic          bit_end;

    // The head byte is taken only from IDLE, so a frame in flight is
    // never disturbed by later pushes.
    assign pop     = (state == UART_IDLE) && !o_empty;
    assign bit_end = (clk_cnt == CLK_LAST);
    assign o_sm_state = state;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (i_wr_en),
        .wr_data      (i_wr_data),
        .pop          (pop),
        .clr_overflow (i_clr_overflow),
        .rd_data      (head),
        .full         (o_full),
        .empty        (o_empty),
        .count        (o_count),
        .overflow     (o_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= UART_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            tx_byte     <= '0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            unique case (state)
                UART_IDLE: begin
                    o_tx_serial <= 1'b1;
                    o_tx_active <= 1'b0;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    if (!o_empty) begin
                        tx_byte     <= head;
                        o_tx_serial <= 1'b0;
                        o_tx_active <= 1'b1;
                        state       <= UART_START;
                    end
                end
                UART_START: begin
                    if (bit_end) begin
                        clk_cnt     <= '0;
                        o_tx_serial <= tx_byte[0];
                        state       <= UART_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                UART_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            o_tx_serial <= 1'b1;
                            state       <= UART_STOP;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            o_tx_serial <= tx_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                UART_STOP: begin
                    if (bit_end) begin
                        clk_cnt     <= '0;
                        o_tx_active <= 1'b0;
                        o_tx_done   <= 1'b1;
                        state       <= UART_CLEANUP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                UART_CLEANUP: begin
                    state <= UART_IDLE;
                end
                default: begin
                    // Codes 5..7 are unreachable; fall back to a quiet line.
                    o_tx_serial <= 1'b1;
                    o_tx_active <= 1'b0;
                    clk_cnt     <= '0;
                    state       <= UART_IDLE;
                end
            endcase
        end
    end

endmodule
